// File: rtl/amber_wb_pkg.sv
// Shared types and constants for the Amber 128-bit Wishbone responder.
// Holds the FSM state encoding, bus widths and the byte-lane merge helper.
package amber_wb_pkg;

    localparam int LINE_W     = 128;
    localparam int SEL_W      = LINE_W / 8;
    localparam int WORD_W     = 32;
    localparam int FIFO_DEPTH = 4;

    localparam logic [WORD_W-1:0] DEF_FILL_WORD = 32'hF0801003;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_ACK  = 2'd2;
    localparam state_t ST_ERR  = 2'd3;

    // Replace only the bytes whose lane enable is set.
    function automatic logic [LINE_W-1:0] byte_merge(
        input logic [LINE_W-1:0] old_line,
        input logic [LINE_W-1:0] new_line,
        input logic [SEL_W-1:0]  sel
    );
        logic [LINE_W-1:0] r;
        r = old_line;
        for (int k = 0; k < SEL_W; k++) begin
            if (sel[k]) r[8*k +: 8] = new_line[8*k +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/amber_inj_fifo.sv
// Four-entry, 32-bit instruction injection FIFO.
// Push is ignored when full and pop when empty, so callers may assert either freely.
module amber_inj_fifo
    import amber_wb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [WORD_W-1:0] data_i,
    input  logic              pop_i,
    output logic [WORD_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [2:0]        count_o
);

    logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
    logic [1:0]        wr_ptr_q, rd_ptr_q;
    logic [2:0]        count_q, count_d;
    logic              push_ok, pop_ok;

    assign full_o  = (count_q == 3'd4);
    assign empty_o = (count_q == 3'd0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    assign count_d = count_q + {2'b00, push_ok} - {2'b00, pop_ok};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 2'd1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 2'd1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/amber_wb_responder.sv
// Wishbone slave backed by a 128-bit line memory, with optional wait states and
// an injection FIFO whose words override read data (wrapped in filler words).
module amber_wb_responder
    import amber_wb_pkg::*;
#(
    parameter int                MEM_DEPTH   = 256,
    parameter int                WAIT_STATES = 0,
    parameter logic [WORD_W-1:0] FILL_WORD   = DEF_FILL_WORD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       i_wb_adr,
    input  logic [SEL_W-1:0]  i_wb_sel,
    input  logic              i_wb_we,
    input  logic [LINE_W-1:0] i_wb_dat,
    input  logic              i_wb_cyc,
    input  logic              i_wb_stb,
    output logic [LINE_W-1:0] o_wb_dat,
    output logic              o_wb_ack,
    output logic              o_wb_err,
    input  logic              inj_valid,
    input  logic [WORD_W-1:0] inj_word,
    output logic              inj_ready,
    output logic [7:0]        err_count
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q;
    logic               we_q;
    logic [SEL_W-1:0]   sel_q;
    logic [LINE_W-1:0]  dat_q;
    logic [7:0]         err_cnt_q;
    logic [LINE_W-1:0]  mem_q [MEM_DEPTH];

    logic               req, in_range, take;
    logic               fifo_full, fifo_empty, inj_hit, pop;
    logic [WORD_W-1:0]  fifo_head;
    logic [2:0]         fifo_cnt;
    logic               unused_ok;

    assign req      = i_wb_cyc & i_wb_stb;
    assign in_range = ({4'd0, i_wb_adr[31:4]} < 32'(MEM_DEPTH));
    assign take     = (state_q == ST_IDLE) & req;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (!in_range) begin
                        state_d = ST_ERR;
                    end else if (WAIT_STATES == 0) begin
                        state_d = ST_ACK;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(WAIT_STATES - 1);
                    end
                end
            end
            ST_WAIT: begin
                // Master abandoning the cycle cancels the access outright.
                if (!i_wb_cyc) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            idx_q     <= '0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            dat_q     <= '0;
            err_cnt_q <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (take) begin
                idx_q <= i_wb_adr[4 +: IDX_W];
                we_q  <= i_wb_we;
                sel_q <= i_wb_sel;
                dat_q <= i_wb_dat;
            end
            if (o_wb_err && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign o_wb_ack  = (state_q == ST_ACK);
    assign o_wb_err  = (state_q == ST_ERR);
    assign err_count = err_cnt_q;

    // Memory is deliberately left out of reset; only the ACK cycle can write it.
    always_ff @(posedge clk) begin
        if (o_wb_ack && we_q) mem_q[idx_q] <= byte_merge(mem_q[idx_q], dat_q, sel_q);
    end

    assign inj_hit  = ~we_q & ~fifo_empty;
    assign pop      = o_wb_ack & inj_hit;
    assign o_wb_dat = !o_wb_ack ? '0 :
                      inj_hit   ? {FILL_WORD, FILL_WORD, FILL_WORD, fifo_head} :
                                  mem_q[idx_q];
    assign inj_ready = ~fifo_full;

    amber_inj_fifo u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (inj_valid),
        .data_i (inj_word),
        .pop_i  (pop),
        .data_o (fifo_head),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .count_o(fifo_cnt)
    );

    assign unused_ok = ^{i_wb_adr[3:0], fifo_cnt};

endmodule

// File: tb/tb_amber_wb_responder.sv
// Bench for amber_wb_responder: one instance with no wait states, one with three.
// Directed table, hand sequences for FIFO/abort/reset corners, then random traffic vs a model.
module tb_amber_wb_responder;

    localparam logic [31:0]  FILL  = 32'hF0801003;
    localparam logic [127:0] PAT_A = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [127:0] PAT_C = 128'hC0C1C2C3C4C5C6C7_C8C9CACBCCCDCECF;
    localparam logic [127:0] PAT_D = 128'hD0D1D2D3D4D5D6D7_D8D9DADBDCDDDEDF;
    localparam logic [127:0] ONES  = {128{1'b1}};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [31:0]  adr;
    logic [15:0]  sel;
    logic         we;
    logic [127:0] wdat;
    logic [31:0]  inj_word;
    logic         cyc [2];
    logic         stb [2];
    logic         inj_v [2];
    logic         ack [2];
    logic         err [2];
    logic         inj_rdy [2];
    logic [127:0] rdat [2];
    logic [7:0]   ecnt [2];

    amber_wb_responder #(.MEM_DEPTH(256), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .i_wb_adr(adr), .i_wb_sel(sel), .i_wb_we(we),
        .i_wb_dat(wdat), .i_wb_cyc(cyc[0]), .i_wb_stb(stb[0]), .o_wb_dat(rdat[0]),
        .o_wb_ack(ack[0]), .o_wb_err(err[0]), .inj_valid(inj_v[0]), .inj_word(inj_word),
        .inj_ready(inj_rdy[0]), .err_count(ecnt[0])
    );

    amber_wb_responder #(.MEM_DEPTH(256), .WAIT_STATES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .i_wb_adr(adr), .i_wb_sel(sel), .i_wb_we(we),
        .i_wb_dat(wdat), .i_wb_cyc(cyc[1]), .i_wb_stb(stb[1]), .o_wb_dat(rdat[1]),
        .o_wb_ack(ack[1]), .o_wb_err(err[1]), .inj_valid(inj_v[1]), .inj_word(inj_word),
        .inj_ready(inj_rdy[1]), .err_count(ecnt[1])
    );

    int checks = 0;
    int errors = 0;

    // Reference model: line memories, injection queue (instance 0 only), error counters.
    logic [127:0] mm [2][256];
    logic [31:0]  fq [$];
    int           ecm [2];

    typedef struct {
        logic [31:0]  a;
        logic         w;
        logic [15:0]  s;
        logic [127:0] dt;
        logic         e;
        logic         cd;
        logic [127:0] x;
    } vec_t;
    vec_t tbl [12];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic void model_txn(input int d, input logic [31:0] a, input logic w,
                                      input logic [15:0] s, input logic [127:0] dt,
                                      output logic e, output logic [127:0] x);
        int line;
        e = 1'b0;
        x = '0;
        line = int'(a[11:4]);
        if (a[31:4] >= 28'd256) begin
            e = 1'b1;
            if (ecm[d] < 255) ecm[d]++;
        end else if (w) begin
            for (int k = 0; k < 16; k++)
                if (s[k]) mm[d][line][8*k +: 8] = dt[8*k +: 8];
        end else if (d == 0 && fq.size() > 0) begin
            x = {FILL, FILL, FILL, fq[0]};
            void'(fq.pop_front());
        end else begin
            x = mm[d][line];
        end
    endfunction

    task automatic run_txn(input int d, input logic [31:0] a, input logic w, input logic [15:0] s,
                           input logic [127:0] dt, input logic exp_err, input logic chk_dat,
                           input logic [127:0] exp_dat, input string nm);
        int lat;
        bit done;
        int exp_lat;
        exp_lat = exp_err ? 1 : (d == 0 ? 1 : 4);
        @(negedge clk);
        adr = a; we = w; sel = s; wdat = dt; cyc[d] = 1'b1; stb[d] = 1'b1;
        lat = 0;
        done = 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (ack[d] || err[d]) done = 1;
        end
        chk({nm, " latency"}, 128'(lat), 128'(exp_lat));
        chk({nm, " ack/err"}, 128'({ack[d], err[d]}), 128'({~exp_err, exp_err}));
        if (chk_dat) chk({nm, " rdata"}, rdat[d], exp_dat);
        @(negedge clk);
        cyc[d] = 1'b0; stb[d] = 1'b0;
        @(posedge clk);
        #1;
        chk({nm, " one-cycle resp"}, 128'({ack[d], err[d]}), 128'(0));
        chk({nm, " idle rdata"}, rdat[d], '0);
        chk({nm, " err_count"}, 128'(ecnt[d]), 128'(ecm[d]));
    endtask

    task automatic model_run(input int d, input logic [31:0] a, input logic w, input logic [15:0] s,
                             input logic [127:0] dt, input string nm);
        logic e;
        logic [127:0] x;
        model_txn(d, a, w, s, dt, e, x);
        run_txn(d, a, w, s, dt, e, !w && !e, x, nm);
    endtask

    task automatic push(input logic [31:0] w);
        @(negedge clk);
        chk("inj_ready before push", 128'(inj_rdy[0]), 128'(fq.size() < 4));
        inj_v[0] = 1'b1;
        inj_word = w;
        if (fq.size() < 4) fq.push_back(w);
        @(negedge clk);
        inj_v[0] = 1'b0;
    endtask

    // Read on instance 0 with an injection push landing in the ACK cycle itself.
    task automatic read_with_push(input logic [31:0] w, input int exp_cnt, input string nm);
        logic [127:0] exp_head;
        bit was_full;
        @(negedge clk);
        adr = 32'h10; we = 1'b0; sel = 16'h0; cyc[0] = 1'b1; stb[0] = 1'b1;
        @(posedge clk);
        #1;
        exp_head = {FILL, FILL, FILL, fq[0]};
        chk({nm, " ack"}, 128'(ack[0]), 128'(1));
        chk({nm, " head"}, rdat[0], exp_head);
        @(negedge clk);
        cyc[0] = 1'b0; stb[0] = 1'b0;
        inj_v[0] = 1'b1; inj_word = w;
        was_full = (fq.size() == 4);
        void'(fq.pop_front());
        if (!was_full) fq.push_back(w);
        @(posedge clk);
        #1;
        chk({nm, " count"}, 128'(dut0.u_fifo.count_o), 128'(exp_cnt));
        chk({nm, " inj_ready"}, 128'(inj_rdy[0]), 128'(exp_cnt < 4));
        @(negedge clk);
        inj_v[0] = 1'b0;
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        rst_n = 1'b0;
        cyc[0] = 1'b0; stb[0] = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0;
        inj_v[0] = 1'b0; inj_v[1] = 1'b0;
        #1;
        fq.delete();
        ecm[0] = 0; ecm[1] = 0;
        for (int d = 0; d < 2; d++) begin
            chk({nm, " ack/err"}, 128'({ack[d], err[d]}), 128'(0));
            chk({nm, " rdata"}, rdat[d], '0);
            chk({nm, " inj_ready"}, 128'(inj_rdy[d]), 128'(1));
            chk({nm, " err_count"}, 128'(ecnt[d]), 128'(0));
        end
        chk({nm, " fifo count"}, 128'(dut0.u_fifo.count_o), 128'(0));
        #2;
        rst_n = 1'b1;
    endtask

    task automatic no_ack_for(input int d, input int n, input string nm);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk(nm, 128'({ack[d], err[d]}), 128'(0));
        end
    endtask

    initial begin
        logic [31:0]  ra;
        logic         rw;
        logic [15:0]  rs;
        logic [127:0] rd;

        tbl[0]  = '{32'h0000_0010, 1'b1, 16'hFFFF, PAT_A, 1'b0, 1'b0, '0};
        tbl[1]  = '{32'h0000_0010, 1'b0, 16'h0000, '0,    1'b0, 1'b1, PAT_A};
        tbl[2]  = '{32'h0000_0000, 1'b1, 16'hFFFF, '0,    1'b0, 1'b0, '0};
        tbl[3]  = '{32'h0000_0000, 1'b1, 16'h0001, ONES,  1'b0, 1'b0, '0};
        tbl[4]  = '{32'h0000_0000, 1'b0, 16'h0000, '0,    1'b0, 1'b1, 128'hFF};
        tbl[5]  = '{32'h0000_1000, 1'b0, 16'h0000, '0,    1'b1, 1'b0, '0};
        tbl[6]  = '{32'h0000_001C, 1'b0, 16'h0000, '0,    1'b0, 1'b1, PAT_A};
        tbl[7]  = '{32'h0000_0014, 1'b1, 16'h0000, ONES,  1'b0, 1'b0, '0};
        tbl[8]  = '{32'h0000_0010, 1'b0, 16'h0000, '0,    1'b0, 1'b1, PAT_A};
        tbl[9]  = '{32'hFFFF_FFF0, 1'b1, 16'hFFFF, ONES,  1'b1, 1'b0, '0};
        tbl[10] = '{32'h0000_0000, 1'b1, 16'h8001, ONES,  1'b0, 1'b0, '0};
        tbl[11] = '{32'h0000_0003, 1'b0, 16'h0000, '0,    1'b0, 1'b1, {8'hFF, 112'd0, 8'hFF}};

        adr = '0; sel = '0; we = 1'b0; wdat = '0; inj_word = '0;
        for (int d = 0; d < 2; d++) begin
            cyc[d] = 1'b0; stb[d] = 1'b0; inj_v[d] = 1'b0; ecm[d] = 0;
        end
        rst_n = 1'b1;
        #3;
        do_reset("reset");
        repeat (2) @(posedge clk);

        for (int i = 0; i < 12; i++) begin
            logic e;
            logic [127:0] x;
            model_txn(0, tbl[i].a, tbl[i].w, tbl[i].s, tbl[i].dt, e, x);
            run_txn(0, tbl[i].a, tbl[i].w, tbl[i].s, tbl[i].dt, tbl[i].e, tbl[i].cd, tbl[i].x,
                    $sformatf("vec%0d", i));
        end

        // Injected word overrides a read once, then memory shows through again.
        push(32'hE3A01005);
        run_txn(0, 32'h10, 1'b0, 16'h0, '0, 1'b0, 1'b1,
                {FILL, FILL, FILL, 32'hE3A01005}, "inject read");
        void'(fq.pop_front());
        run_txn(0, 32'h10, 1'b0, 16'h0, '0, 1'b0, 1'b1, PAT_A, "post-inject read");

        // Writes must not consume an injected word.
        push(32'h1111_0001);
        model_run(0, 32'h30, 1'b1, 16'hFFFF, PAT_C, "write with fifo");
        model_run(0, 32'h10, 1'b0, 16'h0, '0, "read after write w/ fifo");

        for (int i = 0; i < 4; i++) push(32'hA000_0000 + 32'(i));
        @(negedge clk);
        chk("full inj_ready", 128'(inj_rdy[0]), 128'(0));
        chk("full count", 128'(dut0.u_fifo.count_o), 128'(4));
        read_with_push(32'hBAD0_BAD0, 3, "full pop+push");
        read_with_push(32'h5555_0005, 3, "pop+push");
        for (int i = 0; i < 4; i++) model_run(0, 32'h10, 1'b0, 16'h0, '0, "drain");

        push(32'h2222_0001);
        push(32'h2222_0002);
        do_reset("reset pulse");
        model_run(0, 32'h10, 1'b0, 16'h0, '0, "read after reset");

        // Random traffic on lines 0..15 plus some out-of-range addresses.
        for (int l = 0; l < 16; l++)
            model_run(0, 32'(l) << 4, 1'b1, 16'hFFFF,
                      {$urandom, $urandom, $urandom, $urandom}, "rand init");
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 2) == 0) push($urandom);
            if ($urandom_range(0, 7) == 0) begin
                ra = $urandom;
                if (ra < 32'h1000) ra = ra | 32'h1000;
            end else begin
                ra = 32'($urandom_range(0, 255));
            end
            rw = 1'($urandom_range(0, 1));
            rs = 16'($urandom);
            rd = {$urandom, $urandom, $urandom, $urandom};
            model_run(0, ra, rw, rs, rd, $sformatf("rand%0d", i));
        end

        // Wait-state instance: latency, abandoned cycle, reset during wait.
        model_run(1, 32'h10, 1'b1, 16'hFFFF, PAT_C, "ws3 write");
        model_run(1, 32'h20, 1'b1, 16'hFFFF, '0, "ws3 clear");
        model_run(1, 32'h18, 1'b0, 16'h0, '0, "ws3 read");
        @(negedge clk);
        adr = 32'h10; we = 1'b1; sel = 16'hFFFF; wdat = PAT_D; cyc[1] = 1'b1; stb[1] = 1'b1;
        no_ack_for(1, 2, "abort in wait");
        @(negedge clk);
        cyc[1] = 1'b0; stb[1] = 1'b0;
        no_ack_for(1, 4, "after abort");
        model_run(1, 32'h10, 1'b0, 16'h0, '0, "ws3 read after abort");
        @(negedge clk);
        adr = 32'h20; we = 1'b1; sel = 16'hFFFF; wdat = PAT_D; cyc[1] = 1'b1; stb[1] = 1'b1;
        no_ack_for(1, 2, "before reset");
        do_reset("mid-txn reset");
        no_ack_for(1, 4, "after mid-txn reset");
        model_run(1, 32'h20, 1'b0, 16'h0, '0, "ws3 read after reset");
        model_run(1, 32'h2000, 1'b0, 16'h0, '0, "ws3 err");

        // err_count saturation.
        for (int i = 0; i < 258; i++)
            model_run(0, 32'h0001_0000 + 32'(i << 4), 1'b0, 16'h0, '0, "sat err");
        chk("err_count saturated", 128'(ecnt[0]), 128'(255));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
